// File: rtl/console_writer.sv
// console_writer: text console that turns host characters into character-RAM writes with cursor and hardware scroll
module console_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        vgaClock,
    input  logic        rst,
    input  logic [7:0]  charIn,
    input  logic        charValid,
    output logic        charReady,
    output logic [15:0] memWrAddr,
    output logic [7:0]  memWrData,
    output logic        memWrEn,
    output logic [4:0]  rowOffset,
    output logic [6:0]  cursorX,
    output logic [4:0]  cursorY,
    output logic        busy
);
    typedef enum logic [1:0] {CLEAR, IDLE, WRITE, BLANK} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_INC, OP_DEC, OP_CR, OP_LF} op_t;

    localparam logic [15:0] LAST = 16'(ROWS * COLS - 1);
    localparam logic [6:0]  XMAX = 7'(COLS - 1);
    localparam logic [4:0]  YMAX = 5'(ROWS - 1);

    state_t      r_state, w_next;
    op_t         r_op, w_op;
    logic        r_rst, r_we;
    logic [15:0] r_addr, r_end, w_cur_addr, w_row_base;
    logic [7:0]  r_data;
    logic [6:0]  r_x, w_wr_x;
    logic [4:0]  r_y, r_off, w_prow;
    logic [5:0]  w_sum;
    logic        w_accept, w_print, w_bs, w_scroll;

    assign w_accept   = r_state == IDLE && charValid;
    assign w_print    = charIn >= 8'h20 && charIn <= 8'h7E;
    assign w_bs       = charIn == 8'h08 && r_x != 7'd0;
    assign w_sum      = {1'b0, r_y} + {1'b0, r_off};
    assign w_prow     = w_sum >= 6'(ROWS) ? 5'(w_sum - 6'(ROWS)) : w_sum[4:0];
    assign w_wr_x     = w_bs ? r_x - 7'd1 : r_x;
    assign w_cur_addr = 16'(w_prow) * 16'(COLS) + 16'(w_wr_x);
    assign w_row_base = 16'(r_off) * 16'(COLS);
    assign w_scroll   = (r_op == OP_LF || (r_op == OP_INC && r_x == XMAX)) && r_y == YMAX;
    assign w_op       = w_print ? OP_INC : w_bs ? OP_DEC : charIn == 8'h0D ? OP_CR :
                        charIn == 8'h0A ? OP_LF : OP_NONE;
    assign cursorX    = r_x;
    assign cursorY    = r_y;
    assign rowOffset  = r_off;

    // next state plus handshake and RAM strobe; the cycle right after a reset edge never strobes
    always_comb begin
        w_next    = r_state;
        charReady = r_state == IDLE;
        busy      = r_state != IDLE;
        memWrEn   = !r_rst && (r_state == CLEAR || r_state == BLANK || (r_state == WRITE && r_we));
        memWrAddr = r_addr;
        memWrData = r_data;
        case (r_state)
            CLEAR:   w_next = (!r_rst && r_addr == LAST) ? IDLE : CLEAR;
            IDLE:    w_next = !w_accept ? IDLE : charIn == 8'h0C ? CLEAR : WRITE;
            WRITE:   w_next = w_scroll ? BLANK : IDLE;
            BLANK:   w_next = r_addr == r_end ? IDLE : BLANK;
            default: w_next = CLEAR;
        endcase
    end

    // state register; r_rst remembers that the previous edge was a reset edge
    always_ff @(posedge vgaClock) begin
        r_rst   <= rst;
        r_state <= rst ? CLEAR : w_next;
    end

    // datapath: write address/data latched on accept, cursor and scroll applied at the end of WRITE
    always_ff @(posedge vgaClock) begin
        if (rst) begin
            r_addr <= '0;
            r_end  <= '0;
            r_data <= 8'h20;
            r_we   <= 1'b0;
            r_op   <= OP_NONE;
            r_x    <= '0;
            r_y    <= '0;
            r_off  <= '0;
        end else begin
            case (r_state)
                CLEAR: if (!r_rst) begin
                    r_addr <= r_addr == LAST ? '0 : r_addr + 16'd1;
                    if (r_addr == LAST) begin
                        r_x   <= '0;
                        r_y   <= '0;
                        r_off <= '0;
                    end
                end
                IDLE: if (w_accept) begin
                    r_addr <= charIn == 8'h0C ? '0 : w_cur_addr;
                    r_data <= w_print ? charIn : 8'h20;
                    r_we   <= w_print || w_bs;
                    r_op   <= w_op;
                end
                WRITE: begin
                    if (r_op == OP_DEC) r_x <= r_x - 7'd1;
                    else if (r_op == OP_CR) r_x <= '0;
                    else if (r_op == OP_INC && r_x != XMAX) r_x <= r_x + 7'd1;
                    else if (r_op != OP_NONE) begin
                        r_x <= '0;
                        if (r_y != YMAX) r_y <= r_y + 5'd1;
                        else begin
                            r_off  <= r_off == YMAX ? '0 : r_off + 5'd1;
                            r_addr <= w_row_base;
                            r_end  <= w_row_base + 16'(COLS - 1);
                            r_data <= 8'h20;
                        end
                    end
                end
                BLANK: r_addr <= r_addr + 16'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_console_writer.sv
// tb_console_writer: randomized console traffic checked against a screen-level reference model
module tb_console_writer;
    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        vgaClock = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  charIn = 8'h00;
    logic        charValid = 1'b0;
    logic        charReady, memWrEn, busy;
    logic [15:0] memWrAddr;
    logic [7:0]  memWrData;
    logic [4:0]  rowOffset, cursorY;
    logic [6:0]  cursorX;

    int checks = 0;
    int errors = 0;
    int q[$];
    int mx = 0, my = 0, moff = 0;
    bit chk_en = 1'b0;
    int nwr = 0, last_addr = -1, last_data = -1;

    console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .vgaClock(vgaClock), .rst(rst), .charIn(charIn), .charValid(charValid),
        .charReady(charReady), .memWrAddr(memWrAddr), .memWrData(memWrData), .memWrEn(memWrEn),
        .rowOffset(rowOffset), .cursorX(cursorX), .cursorY(cursorY), .busy(busy)
    );

    always #5 vgaClock = ~vgaClock;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int a, input int d);
        q.push_back((a << 8) | d);
    endtask

    task automatic newline(inout int eb);
        mx = 0;
        if (my < ROWS - 1) my++;
        else begin
            for (int i = 0; i < COLS; i++) push(moff * COLS + i, 8'h20);
            moff = (moff + 1) % ROWS;
            eb += COLS;
        end
    endtask

    task automatic model(input logic [7:0] ch, output int eb);
        eb = 1;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            push(((my + moff) % ROWS) * COLS + mx, ch);
            if (mx == COLS - 1) newline(eb);
            else mx++;
        end else if (ch == 8'h0D) mx = 0;
        else if (ch == 8'h0A) newline(eb);
        else if (ch == 8'h08) begin
            if (mx > 0) begin
                mx--;
                push(((my + moff) % ROWS) * COLS + mx, 8'h20);
            end
        end else if (ch == 8'h0C) begin
            for (int i = 0; i < ROWS * COLS; i++) push(i, 8'h20);
            mx = 0;
            my = 0;
            moff = 0;
            eb = ROWS * COLS;
        end
    endtask

    always @(negedge vgaClock) begin
        if (chk_en) begin
            int e;
            chk("busy_vs_ready", int'(busy), int'(!charReady));
            if (memWrEn) begin
                nwr++;
                last_addr = memWrAddr;
                last_data = memWrData;
                if (q.size() == 0) chk("unexpected_write_addr", int'(memWrAddr), -1);
                else begin
                    e = q.pop_front();
                    chk("wr_addr", int'(memWrAddr), e >> 8);
                    chk("wr_data", int'(memWrData), e & 255);
                end
            end
            if (charReady) begin
                chk("pending_writes", q.size(), 0);
                chk("cursor_x", int'(cursorX), mx);
                chk("cursor_y", int'(cursorY), my);
                chk("row_offset", int'(rowOffset), moff);
            end
        end
    end

    task automatic do_reset();
        int n;
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge vgaClock);
        @(negedge vgaClock);
        chk("rst_wr_en", int'(memWrEn), 0);
        chk("rst_ready", int'(charReady), 0);
        q.delete();
        mx = 0;
        my = 0;
        moff = 0;
        for (int i = 0; i < ROWS * COLS; i++) push(i, 8'h20);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge vgaClock);
        chk("first_clear_en", int'(memWrEn), 1);
        chk("first_clear_addr", int'(memWrAddr), 0);
        n = 1;
        while (!charReady && n < 5000) begin
            @(negedge vgaClock);
            if (!charReady) n++;
        end
        chk("clear_cycles", n, ROWS * COLS);
    endtask

    task automatic accept(input logic [7:0] ch, output int eb);
        int n = 0;
        while (!charReady && n < 5000) begin
            @(negedge vgaClock);
            n++;
        end
        chk("ready_before_send", int'(charReady), 1);
        charIn = ch;
        charValid = 1'b1;
        @(posedge vgaClock);
        #1;
        charValid = 1'b0;
        charIn = 8'($urandom);
        model(ch, eb);
    endtask

    task automatic send(input logic [7:0] ch, output int n);
        int eb;
        accept(ch, eb);
        n = 0;
        @(negedge vgaClock);
        while (!charReady && n < 5000) begin
            n++;
            @(negedge vgaClock);
        end
        chk("busy_cycles", n, eb);
    endtask

    initial begin
        int n, w, r, eb;
        logic [7:0] c;
        do_reset();
        chk("reset_x", int'(cursorX), 0);
        chk("reset_y", int'(cursorY), 0);
        chk("reset_off", int'(rowOffset), 0);

        send(8'h41, n);
        chk("A_busy", n, 1);
        chk("A_addr", last_addr, 0);
        chk("A_data", last_data, 8'h41);
        chk("A_x", int'(cursorX), 1);
        chk("A_y", int'(cursorY), 0);

        w = nwr;
        repeat (79) send(8'h41, n);
        chk("row_fill_writes", nwr - w, 79);
        chk("row_fill_last_addr", last_addr, 79);
        chk("row_fill_x", int'(cursorX), 0);
        chk("row_fill_y", int'(cursorY), 1);

        repeat (28) send(8'h0A, n);
        repeat (7) send(8'h78, n);
        chk("bottom_x", int'(cursorX), 7);
        chk("bottom_y", int'(cursorY), 29);
        w = nwr;
        send(8'h0A, n);
        chk("scroll_busy", n, 81);
        chk("scroll_writes", nwr - w, 80);
        chk("scroll_last_addr", last_addr, 79);
        chk("scroll_off", int'(rowOffset), 1);
        chk("scroll_x", int'(cursorX), 0);
        chk("scroll_y", int'(cursorY), 29);
        send(8'h42, n);
        chk("after_scroll_addr", last_addr, 0);
        chk("after_scroll_data", last_data, 8'h42);

        send(8'h0C, n);
        chk("ff_busy", n, ROWS * COLS);
        repeat (2) send(8'h0A, n);
        repeat (5) send(8'h63, n);
        send(8'h08, n);
        chk("bs_addr", last_addr, 164);
        chk("bs_data", last_data, 8'h20);
        chk("bs_x", int'(cursorX), 4);
        chk("bs_y", int'(cursorY), 2);
        send(8'h0D, n);
        send(8'h0A, n);
        w = nwr;
        send(8'h08, n);
        chk("bs_col0_writes", nwr - w, 0);
        chk("bs_col0_x", int'(cursorX), 0);
        chk("bs_col0_y", int'(cursorY), 3);

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) c = 8'($urandom_range(32, 126));
            else if (r < 75) c = 8'h0A;
            else if (r < 82) c = 8'h0D;
            else if (r < 92) c = 8'h08;
            else begin
                c = 8'($urandom_range(0, 255));
                if ((c >= 8'h20 && c <= 8'h7E) || c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D)
                    c = 8'h7F;
            end
            send(c, n);
        end

        accept(8'h0C, eb);
        n = 0;
        @(negedge vgaClock);
        while (!(memWrEn && memWrAddr == 16'd500) && n < 5000) begin
            n++;
            @(negedge vgaClock);
        end
        chk("abort_point_addr", int'(memWrAddr), 500);
        #1;
        do_reset();
        send(8'h41, n);
        chk("post_abort_addr", last_addr, 0);
        chk("post_abort_data", last_data, 8'h41);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
